// File: rtl/moldudp64_seq_ctrl.sv
// MoldUDP64 sequence controller: session lock, accept/drop, gap requests.
// Ports: hdr_* / msg_end_i / pkt_end_i in; accept/drop, sid, exp_seq, gap_req_*, sess_end, err out.
module moldudp64_seq_ctrl #(
  parameter int SID_W = 80,
  parameter int SEQ_W = 64,
  parameter int CNT_W = 16,
  parameter logic [CNT_W-1:0] REQ_MAX = 16'd1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hdr_v_i,
  input  logic [SID_W-1:0] hdr_sid_i,
  input  logic [SEQ_W-1:0] hdr_seq_i,
  input  logic [CNT_W-1:0] hdr_cnt_i,
  input  logic             msg_end_i,
  input  logic             pkt_end_i,
  output logic             accept_o,
  output logic             drop_o,
  output logic             sid_v_o,
  output logic [SID_W-1:0] sid_o,
  output logic [SEQ_W-1:0] exp_seq_o,
  output logic             gap_req_v_o,
  output logic [SEQ_W-1:0] gap_req_seq_o,
  output logic [CNT_W-1:0] gap_req_cnt_o,
  input  logic             gap_req_ready_i,
  output logic             sess_end_o,
  output logic             err_o
);

  typedef enum logic [1:0] {IDLE, ACC, DRP} state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] hdr_cnt_q;
  logic [CNT_W-1:0] msg_cnt_q;
  logic [CNT_W-1:0] msg_cnt_nxt;
  logic [CNT_W-1:0] eff_cnt;
  logic [CNT_W-1:0] gap_cnt;
  logic [SEQ_W-1:0] seq_diff;
  logic             hdr_go;
  logic             eos;
  logic             eos_hit;
  logic             hdr_acc;
  logic             hdr_gap;
  logic             err_set;

  assign hdr_go      = hdr_v_i && (state_q == IDLE);
  assign eos         = (hdr_cnt_i == '1);
  // End-of-session header carries no messages.
  assign eff_cnt     = eos ? '0 : hdr_cnt_i;
  assign seq_diff    = hdr_seq_i - exp_seq_o;
  assign msg_cnt_nxt = msg_cnt_q + CNT_W'(msg_end_i);
  assign gap_cnt     = (seq_diff > SEQ_W'(REQ_MAX)) ?
                       REQ_MAX : seq_diff[CNT_W-1:0];
  assign eos_hit     = eos && !sess_end_o &&
                       (!sid_v_o || (hdr_sid_i == sid_o));

  always_comb begin
    hdr_acc = 1'b0;
    hdr_gap = 1'b0;
    if (sess_end_o) begin
      hdr_acc = 1'b0;
    end else if (!sid_v_o) begin
      hdr_acc = 1'b1;
    end else if (hdr_sid_i != sid_o) begin
      hdr_acc = 1'b0;
    end else if (hdr_seq_i == exp_seq_o) begin
      hdr_acc = 1'b1;
    end else if (hdr_seq_i > exp_seq_o) begin
      hdr_gap = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (hdr_v_i && !pkt_end_i)
          state_d = hdr_acc ? ACC : DRP;
        if (pkt_end_i && !hdr_v_i)
          err_set = 1'b1;
        // Packet completed in its header cycle: nothing was counted.
        if (hdr_v_i && pkt_end_i && hdr_acc &&
            (CNT_W'(msg_end_i) != eff_cnt))
          err_set = 1'b1;
      end
      ACC: begin
        if (pkt_end_i)
          state_d = IDLE;
        if (hdr_v_i)
          err_set = 1'b1;
        if (msg_end_i && (msg_cnt_q >= hdr_cnt_q))
          err_set = 1'b1;
        if (pkt_end_i && (msg_cnt_nxt != hdr_cnt_q))
          err_set = 1'b1;
      end
      DRP: begin
        if (pkt_end_i)
          state_d = IDLE;
        if (hdr_v_i)
          err_set = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      accept_o      <= 1'b0;
      drop_o        <= 1'b0;
      sid_v_o       <= 1'b0;
      sid_o         <= '0;
      exp_seq_o     <= '0;
      gap_req_v_o   <= 1'b0;
      gap_req_seq_o <= '0;
      gap_req_cnt_o <= '0;
      sess_end_o    <= 1'b0;
      err_o         <= 1'b0;
      hdr_cnt_q     <= '0;
      msg_cnt_q     <= '0;
    end else begin
      if (hdr_go) begin
        accept_o  <= hdr_acc;
        drop_o    <= !hdr_acc;
        hdr_cnt_q <= eff_cnt;
        msg_cnt_q <= '0;
      end else if ((state_q == IDLE) || pkt_end_i) begin
        accept_o <= 1'b0;
        drop_o   <= 1'b0;
      end
      if (state_q == ACC && msg_end_i)
        msg_cnt_q <= msg_cnt_nxt;
      if (hdr_go && !sess_end_o && !sid_v_o) begin
        sid_v_o <= 1'b1;
        sid_o   <= hdr_sid_i;
      end
      if (hdr_go && hdr_acc)
        exp_seq_o <= pkt_end_i ? hdr_seq_i + SEQ_W'(eff_cnt)
                               : hdr_seq_i;
      else if (state_q == ACC && pkt_end_i)
        exp_seq_o <= exp_seq_o + SEQ_W'(hdr_cnt_q);
      if (hdr_go && eos_hit)
        sess_end_o <= 1'b1;
      if (err_set)
        err_o <= 1'b1;
      // A pending request is never overwritten by a later gap.
      if (gap_req_v_o && gap_req_ready_i) begin
        gap_req_v_o <= 1'b0;
      end else if (!gap_req_v_o && hdr_go && hdr_gap) begin
        gap_req_v_o   <= 1'b1;
        gap_req_seq_o <= exp_seq_o;
        gap_req_cnt_o <= gap_cnt;
      end
    end
  end

endmodule
